// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch block.
//   fetch_state_t : fetch FSM states (FAULT is reachable only when the
//                   FETCH_BOUND_CHECK_EN build option is defined)
//   INST_BYTES    : byte stride between sequential instruction words
//   fetch_entry_t : one prefetch buffer entry {pc, inst}
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of fetch entries with synchronous flush.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the write pointer
//   pop        : advance the read pointer
//   flush      : empty the buffer; wins over push and pop
//   count      : number of valid entries (0..DEPTH)
//   head       : entry at the read pointer (storage value, even when empty)
// The caller guarantees no push when full unless a pop happens in the same cycle.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: owns the PC, fetches sequentially from a
// combinational instruction memory and buffers {pc, inst} pairs for decode.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   fetch_en                  : allow new fetches (pops continue when low)
//   imem_addr / imem_inst     : instruction memory address / read data
//   redirect_valid/_pc        : branch/jump redirect from execute
//   out_valid/_ready/_inst/_pc: valid/ready handshake towards decode
//   fetch_fault               : sticky out-of-bounds/misaligned fetch flag
// Build option FETCH_BOUND_CHECK_EN: enables the PC bound/alignment check and
// the FAULT state; without it fetch_fault stays 0 and any PC is fetched.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * INST_BYTES);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          fault_q, fault_set, fault_clr;
  logic          push, pop, room;
  logic [CW-1:0] count;
  logic [31:0]   redirect_target;
  logic          pc_bad, target_ok;
  fetch_entry_t  din, head;

`ifdef FETCH_BOUND_CHECK_EN
  // Misaligned redirect targets keep their low bits so the check can catch them.
  assign redirect_target = redirect_pc;
  assign pc_bad          = (pc_q[1:0] != 2'b00) | (pc_q >= PC_LIMIT);
  assign target_ok       = (redirect_pc[1:0] == 2'b00) & (redirect_pc < PC_LIMIT);
`else
  logic unused_bits;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign pc_bad          = 1'b0;
  assign target_ok       = 1'b1;
  // Bits not needed when the bound check is compiled out.
  assign unused_bits     = ^{redirect_pc[1:0], PC_LIMIT};
`endif

  assign pop  = out_valid & out_ready;
  assign room = (count < CW'(DEPTH)) | pop;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push      = 1'b0;
    fault_set = 1'b0;
    fault_clr = 1'b0;
    case (state_q)
      BOOT: begin
        // One settle cycle for imem_addr after reset release.
        state_d = RUN;
        if (redirect_valid) pc_d = redirect_target;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (pc_bad) begin
          state_d   = FAULT;
          fault_set = 1'b1;
        end else if (fetch_en && room) begin
          push = 1'b1;
          pc_d = pc_q + 32'(INST_BYTES);
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (target_ok) begin
            state_d   = RUN;
            fault_clr = 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fault_set)      fault_q <= 1'b1;
      else if (fault_clr) fault_q <= 1'b0;
    end
  end

  assign din.pc   = pc_q;
  assign din.inst = imem_inst;

  // A redirect flushes the buffer; a same-cycle pop counts as consumed.
  if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  assign imem_addr   = pc_q;
  assign out_valid   = (count != '0);
  assign out_inst    = head.inst;
  assign out_pc      = head.pc;
  assign fetch_fault = fault_q;

endmodule
